array_seq_ctrl: RTL and testbench
=================================

ARRAY_SEQ_CTRL -- requirements
Module: array_seq_ctrl

Interface
REQ-001 SHALL take parameters: HEIGHT, default 16, array rows; WIDTH, default 16, array columns; CWIDTH, default 8, MAC-window counter width; TWIDTH, default 16, vector counter width.
REQ-002 SHALL provide ports: clk  in  1  sole clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  job request, sampled in IDLE only.
REQ-005 num_vec  in  TWIDTH  input vectors per job, latched at start.
REQ-006 mac_cyc  in  CWIDTH  cycles per rate-coded MAC window, latched at start; 0 treated as 1.
REQ-007 busy  out  1  high in any state except IDLE.
REQ-008 done  out  1  one-cycle pulse at job end.
REQ-009 wght_rd  out  1  weight-row fetch strobe; ifm_rd  out  1  ifm-vector fetch strobe; ofm_vld  out  1  ofm column data valid.
REQ-010 en_i, clr_i, mac_done  out  HEIGHT each  row-border controls, row h skewed h cycles.
REQ-011 en_w, clr_w, en_o, clr_o  out  WIDTH each  column controls, all bits equal.

Function
REQ-012 SHALL implement FSM IDLE -> WLOAD -> COMPUTE -> FLUSH -> OUT -> DONE -> IDLE.
REQ-013 IDLE: start=1 latches num_vec and mac_cyc, moves to WLOAD next cycle; start in any other state is ignored.
REQ-014 WLOAD: exactly HEIGHT cycles; en_w all-ones and wght_rd=1 every cycle; clr_w and clr_o all-ones in first cycle only.
REQ-015 WLOAD exit: num_vec=0 -> DONE; otherwise -> COMPUTE.
REQ-016 COMPUTE: num_vec windows of M=max(mac_cyc,1) cycles each, back-to-back, total num_vec*M cycles.
REQ-017 Row-0 base signals in COMPUTE: en_i=1 every cycle; clr_i=1 and ifm_rd=1 in first window cycle; mac_done=1 in last window cycle; M=1 gives clr_i, mac_done and ifm_rd all in the same cycle.
REQ-018 Base signals SHALL be 0 outside COMPUTE.
REQ-019 Row h outputs en_i[h], clr_i[h], mac_done[h] SHALL equal the row-0 base delayed h cycles; row 0 undelayed.
REQ-020 FLUSH: exactly HEIGHT+WIDTH-1 cycles, base signals 0; skewed rows drain.
REQ-021 OUT: exactly HEIGHT cycles; en_o all-ones and ofm_vld=1.
REQ-022 DONE: one cycle; done=1; then IDLE.
REQ-023 Window counter CWIDTH bits, vector counter TWIDTH bits; neither wraps. num_vec=2^TWIDTH-1 and mac_cyc=2^CWIDTH-1 SHALL complete correctly.
REQ-024 All outputs registered; no combinational path from input to output.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, clear counters, latched config and all skew stages, in any state including mid-job.
REQ-026 Every output SHALL be 0 in the cycle after a reset edge.
REQ-027 start asserted during rst SHALL be ignored.

Structure
REQ-028 Package array_ctrl_pkg SHALL hold the state enum (IDLE, WLOAD, COMPUTE, FLUSH, OUT, DONE) and FLUSH length constant.
REQ-029 One sub-module, skew_line: parameterised DEPTH shift register with synchronous reset, instantiated once per skewed control (en_i, clr_i, mac_done); tap h gives delay h.

Verification (HEIGHT=WIDTH=4 unless noted)
REQ-030 start, num_vec=2, mac_cyc=3 -> WLOAD 4 cycles (clr_w/clr_o on first), COMPUTE 6 cycles, ifm_rd at compute cycles 0 and 3, mac_done[0] at cycles 2 and 5, mac_done[3] at cycles 5 and 8, FLUSH 7, OUT 4, done pulse; busy high 22 cycles.
REQ-031 num_vec=1, mac_cyc=0 -> single COMPUTE cycle with clr_i[0]=mac_done[0]=ifm_rd=1.
REQ-032 num_vec=0 -> WLOAD 4 cycles then done; en_i, ifm_rd and en_o never asserted.
REQ-033 rst pulsed in COMPUTE cycle 2 of REQ-030 job -> all outputs 0 next cycle, no delayed en_i ever appears; new start runs full job.
REQ-034 start held high throughout a job -> exactly one job accepted until IDLE, then a second job starts immediately.
REQ-035 HEIGHT=WIDTH=16, num_vec=3, mac_cyc=255 -> en_i[15] equals en_i[0] delayed 15 cycles bit-exact, OUT lasts 16 cycles.

Source files
------------

// File: rtl/array_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// array_ctrl_pkg
//
// Shared definitions for the systolic-array sequencing controller.
//   state_e   : controller phases, in the order a job walks through them
//   flush_len : number of drain cycles after the last compute cycle. A value
//               injected at row 0 needs HEIGHT-1 cycles to reach the last row
//               and a further WIDTH cycles to ripple across the columns, so
//               the array is quiet after HEIGHT+WIDTH-1 cycles.
// ---------------------------------------------------------------------------
package array_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    COMPUTE,
    FLUSH,
    OUT,
    DONE
  } state_e;

  // FLUSH phase length for a given array geometry.
  function automatic int flush_len(input int height, input int width);
    return height + width - 1;
  endfunction

endpackage

// File: rtl/array_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// array_seq_ctrl_if
//
// Bundle between a job issuer (master) and the array sequencer (slave).
//   start    : job request
//   num_vec  : input vectors for the job
//   mac_cyc  : cycles per rate-coded MAC window (0 behaves like 1)
//   busy     : sequencer not idle
//   done     : one-cycle end-of-job pulse
//   wght_rd / ifm_rd / ofm_vld : memory-side strobes
//   en_i, clr_i, mac_done      : per-row controls, row h skewed by h cycles
//   en_w, clr_w, en_o, clr_o   : per-column controls, all bits identical
// ---------------------------------------------------------------------------
interface array_seq_ctrl_if #(
  parameter int HEIGHT = 16,
  parameter int WIDTH  = 16,
  parameter int CWIDTH = 8,
  parameter int TWIDTH = 16
);

  logic              start;
  logic [TWIDTH-1:0] num_vec;
  logic [CWIDTH-1:0] mac_cyc;

  logic              busy;
  logic              done;
  logic              wght_rd;
  logic              ifm_rd;
  logic              ofm_vld;

  logic [HEIGHT-1:0] en_i;
  logic [HEIGHT-1:0] clr_i;
  logic [HEIGHT-1:0] mac_done;

  logic [WIDTH-1:0]  en_w;
  logic [WIDTH-1:0]  clr_w;
  logic [WIDTH-1:0]  en_o;
  logic [WIDTH-1:0]  clr_o;

  // Job issuer side.
  modport master (
    output start, num_vec, mac_cyc,
    input  busy, done, wght_rd, ifm_rd, ofm_vld,
    input  en_i, clr_i, mac_done,
    input  en_w, clr_w, en_o, clr_o
  );

  // Sequencer side.
  modport slave (
    input  start, num_vec, mac_cyc,
    output busy, done, wght_rd, ifm_rd, ofm_vld,
    output en_i, clr_i, mac_done,
    output en_w, clr_w, en_o, clr_o
  );

endinterface

// File: rtl/array_seq_ctrl_skew_line.sv
// ---------------------------------------------------------------------------
// skew_line
//
// Delay line producing DEPTH taps of one control bit; tap h is the input
// delayed by h clock cycles (tap 0 is the input itself). Used to stagger a
// row control so row h of the array sees it h cycles after row 0.
//   clk   : clock
//   rst   : synchronous active-high reset, clears every stage
//   d_i   : bit to be skewed
//   tap_o : tap h = d_i delayed h cycles
// ---------------------------------------------------------------------------
module skew_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_i,
  output logic [DEPTH-1:0] tap_o
);

  generate
    if (DEPTH > 1) begin : g_shift
      logic [DEPTH-2:0] stage_q;

      // Plain shift register; stage i holds the input from i+1 cycles ago.
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_q <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH - 1; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign tap_o = {stage_q, d_i};
    end else begin : g_pass
      assign tap_o = d_i;
    end
  endgenerate

endmodule

// File: rtl/array_seq_ctrl.sv
// ---------------------------------------------------------------------------
// array_seq_ctrl
//
// Sequencer for a HEIGHT x WIDTH rate-coded MAC array. A job loads weights
// (WLOAD, HEIGHT cycles), streams num_vec input vectors with one MAC window of
// max(mac_cyc,1) cycles each (COMPUTE), waits for the skewed wavefront to
// leave the array (FLUSH), reads the results out (OUT) and pulses done.
//   clk : clock
//   rst : synchronous active-high reset; aborts any job
//   bus : array_seq_ctrl_if slave modport (job request in, controls out)
// Every output is a flop (or a flop followed by the skew shift register), so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module array_seq_ctrl #(
  parameter int HEIGHT = 16,
  parameter int WIDTH  = 16,
  parameter int CWIDTH = 8,
  parameter int TWIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  array_seq_ctrl_if.slave bus
);

  import array_ctrl_pkg::*;

  localparam int FLUSH_LEN = flush_len(HEIGHT, WIDTH);
  // Shared phase counter for WLOAD, FLUSH and OUT; FLUSH is the longest.
  localparam int PW = $clog2(HEIGHT + WIDTH) + 1;

  state_e            state_q;
  logic [TWIDTH-1:0] numVec_q;
  logic [TWIDTH-1:0] vecCnt_q;
  logic [CWIDTH-1:0] macLast_q;
  logic [CWIDTH-1:0] winCnt_q;
  logic [PW-1:0]     phaseCnt_q;

  logic busy_q;
  logic done_q;
  logic wghtRd_q;
  logic ifmRd_q;
  logic ofmVld_q;
  logic enW_q;
  logic clrW_q;
  logic enO_q;
  logic clrO_q;
  logic enIBase_q;
  logic clrIBase_q;
  logic macDoneBase_q;

  logic winLast;
  logic vecLast;
  logic winPenult;
  logic winSingle;

  logic [HEIGHT-1:0] enITap;
  logic [HEIGHT-1:0] clrITap;
  logic [HEIGHT-1:0] macDoneTap;

  // Window bookkeeping. macLast_q stores M-1 so the counters only ever count
  // up to the last index and never wrap, even at the all-ones maximum.
  always_comb begin
    winLast   = (winCnt_q == macLast_q);
    vecLast   = (vecCnt_q == numVec_q - TWIDTH'(1));
    winPenult = (winCnt_q + CWIDTH'(1) == macLast_q);
    winSingle = (macLast_q == '0);
  end

  // Controller FSM. Outputs are registered, so each transition also loads
  // the output values for the first cycle of the state being entered; the
  // pulse-type outputs default to 0 and are re-asserted while they must stay
  // high. busy is held and only changes on entering or leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      numVec_q      <= '0;
      vecCnt_q      <= '0;
      macLast_q     <= '0;
      winCnt_q      <= '0;
      phaseCnt_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wghtRd_q      <= 1'b0;
      ifmRd_q       <= 1'b0;
      ofmVld_q      <= 1'b0;
      enW_q         <= 1'b0;
      clrW_q        <= 1'b0;
      enO_q         <= 1'b0;
      clrO_q        <= 1'b0;
      enIBase_q     <= 1'b0;
      clrIBase_q    <= 1'b0;
      macDoneBase_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      wghtRd_q      <= 1'b0;
      ifmRd_q       <= 1'b0;
      ofmVld_q      <= 1'b0;
      enW_q         <= 1'b0;
      clrW_q        <= 1'b0;
      enO_q         <= 1'b0;
      clrO_q        <= 1'b0;
      enIBase_q     <= 1'b0;
      clrIBase_q    <= 1'b0;
      macDoneBase_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= WLOAD;
            numVec_q   <= bus.num_vec;
            macLast_q  <= (bus.mac_cyc == '0) ? '0 : bus.mac_cyc - CWIDTH'(1);
            phaseCnt_q <= '0;
            busy_q     <= 1'b1;
            enW_q      <= 1'b1;
            wghtRd_q   <= 1'b1;
            clrW_q     <= 1'b1;
            clrO_q     <= 1'b1;
          end
        end

        WLOAD: begin
          if (phaseCnt_q == PW'(HEIGHT - 1)) begin
            if (numVec_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q       <= COMPUTE;
              winCnt_q      <= '0;
              vecCnt_q      <= '0;
              enIBase_q     <= 1'b1;
              clrIBase_q    <= 1'b1;
              ifmRd_q       <= 1'b1;
              macDoneBase_q <= winSingle;
            end
          end else begin
            phaseCnt_q <= phaseCnt_q + PW'(1);
            enW_q      <= 1'b1;
            wghtRd_q   <= 1'b1;
          end
        end

        COMPUTE: begin
          if (winLast) begin
            if (vecLast) begin
              state_q    <= FLUSH;
              phaseCnt_q <= '0;
            end else begin
              vecCnt_q      <= vecCnt_q + TWIDTH'(1);
              winCnt_q      <= '0;
              enIBase_q     <= 1'b1;
              clrIBase_q    <= 1'b1;
              ifmRd_q       <= 1'b1;
              macDoneBase_q <= winSingle;
            end
          end else begin
            winCnt_q      <= winCnt_q + CWIDTH'(1);
            enIBase_q     <= 1'b1;
            macDoneBase_q <= winPenult;
          end
        end

        FLUSH: begin
          if (phaseCnt_q == PW'(FLUSH_LEN - 1)) begin
            state_q    <= OUT;
            phaseCnt_q <= '0;
            enO_q      <= 1'b1;
            ofmVld_q   <= 1'b1;
          end else begin
            phaseCnt_q <= phaseCnt_q + PW'(1);
          end
        end

        OUT: begin
          if (phaseCnt_q == PW'(HEIGHT - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            phaseCnt_q <= phaseCnt_q + PW'(1);
            enO_q      <= 1'b1;
            ofmVld_q   <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Row skew: row h sees the row-0 control h cycles later.
  skew_line #(.DEPTH(HEIGHT)) u_enSkew (
    .clk   (clk),
    .rst   (rst),
    .d_i   (enIBase_q),
    .tap_o (enITap)
  );

  skew_line #(.DEPTH(HEIGHT)) u_clrSkew (
    .clk   (clk),
    .rst   (rst),
    .d_i   (clrIBase_q),
    .tap_o (clrITap)
  );

  skew_line #(.DEPTH(HEIGHT)) u_macDoneSkew (
    .clk   (clk),
    .rst   (rst),
    .d_i   (macDoneBase_q),
    .tap_o (macDoneTap)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wght_rd  = wghtRd_q;
  assign bus.ifm_rd   = ifmRd_q;
  assign bus.ofm_vld  = ofmVld_q;
  assign bus.en_i     = enITap;
  assign bus.clr_i    = clrITap;
  assign bus.mac_done = macDoneTap;
  assign bus.en_w     = {WIDTH{enW_q}};
  assign bus.clr_w    = {WIDTH{clrW_q}};
  assign bus.en_o     = {WIDTH{enO_q}};
  assign bus.clr_o    = {WIDTH{clrO_q}};

endmodule

// File: tb/tb_array_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_array_seq_ctrl
//
// Two sequencers share clock and reset: dutA is a small 4x4 array with narrow
// counters so the all-ones job sizes finish quickly, dutB is the 16x16 default
// geometry. A job-timeline model predicts every output from the cycle index
// within the job; the stimulus process compares both DUTs against it every
// cycle and also checks a few hand-computed event counts and positions.
// ---------------------------------------------------------------------------
module tb_array_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  array_seq_ctrl_if #(.HEIGHT(4),  .WIDTH(4),  .CWIDTH(4), .TWIDTH(6))  busA ();
  array_seq_ctrl_if #(.HEIGHT(16), .WIDTH(16), .CWIDTH(8), .TWIDTH(16)) busB ();

  array_seq_ctrl #(.HEIGHT(4), .WIDTH(4), .CWIDTH(4), .TWIDTH(6)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  array_seq_ctrl #(.HEIGHT(16), .WIDTH(16), .CWIDTH(8), .TWIDTH(16)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  int compared   = 0;
  int mismatched = 0;

  // Job timeline model: a job is a list of phase lengths, and the row-0
  // controls repeat every window of M cycles inside the compute phase.
  bit actA, actB;
  int tA, tB, nvA, nvB, mA, mB;

  function automatic int winLen(input int m);
    return (m == 0) ? 1 : m;
  endfunction

  function automatic int jobLen(input int h, input int w, input int nv, input int m);
    if (nv == 0) return h + 1;
    return h + nv * winLen(m) + (h + w - 1) + h + 1;
  endfunction

  // {en, clr, mac_done} seen by row 0 at job cycle t.
  function automatic logic [2:0] rowBase(input int h, input int nv, input int m, input int t);
    int bigM;
    int c;
    bigM = winLen(m);
    c    = t - h;
    if (c < 0 || c >= nv * bigM) return 3'b000;
    return {1'b1, (c % bigM) == 0, (c % bigM) == bigM - 1};
  endfunction

  // Packed layout: [0] busy [1] done [2] wght_rd [3] ifm_rd [4] ofm_vld,
  // 16-bit fields en_w@8 clr_w@24 en_o@40 clr_o@56 en_i@72 clr_i@88 mac_done@104.
  function automatic logic [127:0] expPack(input int h, input int w, input int nv,
                                           input int m, input int t, input bit act);
    logic [127:0] p;
    logic [15:0]  colMask;
    logic [2:0]   b;
    int           outStart;
    p = '0;
    if (!act) return p;
    colMask = 16'((1 << w) - 1);
    p[0] = 1'b1;
    if (t < h) begin
      p[2]      = 1'b1;
      p[8+:16]  = colMask;
      if (t == 0) begin
        p[24+:16] = colMask;
        p[56+:16] = colMask;
      end
    end
    if (nv == 0) begin
      if (t == h) p[1] = 1'b1;
    end else begin
      b        = rowBase(h, nv, m, t);
      p[3]     = b[1];
      outStart = h + nv * winLen(m) + (h + w - 1);
      if (t >= outStart && t < outStart + h) begin
        p[4]      = 1'b1;
        p[40+:16] = colMask;
      end
      if (t == outStart + h) p[1] = 1'b1;
    end
    for (int r = 0; r < h; r++) begin
      b = rowBase(h, nv, m, t - r);
      p[72 + r]  = b[2];
      p[88 + r]  = b[1];
      p[104 + r] = b[0];
    end
    return p;
  endfunction

  // Model state advances on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    if (rst) begin
      actA <= 1'b0;
      actB <= 1'b0;
    end else begin
      if (actA) begin
        if (tA + 1 >= jobLen(4, 4, nvA, mA)) actA <= 1'b0;
        tA <= tA + 1;
      end else if (busA.start) begin
        actA <= 1'b1;
        tA   <= 0;
        nvA  <= int'(busA.num_vec);
        mA   <= int'(busA.mac_cyc);
      end
      if (actB) begin
        if (tB + 1 >= jobLen(16, 16, nvB, mB)) actB <= 1'b0;
        tB <= tB + 1;
      end else if (busB.start) begin
        actB <= 1'b1;
        tB   <= 0;
        nvB  <= int'(busB.num_vec);
        mB   <= int'(busB.mac_cyc);
      end
    end
  end

  function automatic logic [127:0] packA();
    logic [127:0] p;
    p = '0;
    p[0] = busA.busy;     p[1] = busA.done;   p[2] = busA.wght_rd;
    p[3] = busA.ifm_rd;   p[4] = busA.ofm_vld;
    p[8+:16]   = 16'(busA.en_w);
    p[24+:16]  = 16'(busA.clr_w);
    p[40+:16]  = 16'(busA.en_o);
    p[56+:16]  = 16'(busA.clr_o);
    p[72+:16]  = 16'(busA.en_i);
    p[88+:16]  = 16'(busA.clr_i);
    p[104+:16] = 16'(busA.mac_done);
    return p;
  endfunction

  function automatic logic [127:0] packB();
    logic [127:0] p;
    p = '0;
    p[0] = busB.busy;     p[1] = busB.done;   p[2] = busB.wght_rd;
    p[3] = busB.ifm_rd;   p[4] = busB.ofm_vld;
    p[8+:16]   = busB.en_w;
    p[24+:16]  = busB.clr_w;
    p[40+:16]  = busB.en_o;
    p[56+:16]  = busB.clr_o;
    p[72+:16]  = busB.en_i;
    p[88+:16]  = busB.clr_i;
    p[104+:16] = busB.mac_done;
    return p;
  endfunction

  // Event counters and positions, all maintained by the stimulus process.
  bit checking = 1'b0;
  int cycIdx   = 0;
  int jobMark  = 0;
  int cntBusyA = 0, cntIfmA = 0, cntDoneA = 0, cntMacd3A = 0, cntEnoA = 0;
  int cntEnIanyA = 0, cntTripleA = 0;
  int cntBusyB = 0, cntOfmB = 0, cntEnI15B = 0;
  int ifmAt [4];
  int macd3At [4];
  int ifmN = 0, macd3N = 0;

  task automatic checkOutput(input string name, input int idx,
                             input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0d: got=%h expected=%h", name, idx, got, exp);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    checkOutput(name, -1, 128'(got), 128'(exp));
  endtask

  // One cycle: compare at the falling edge, then move past the rising edge.
  task automatic step();
    int idx;
    @(negedge clk);
    idx = cycIdx;
    cycIdx++;
    if (checking) begin
      checkOutput("cycleA", idx, packA(), expPack(4, 4, nvA, mA, tA, actA));
      checkOutput("cycleB", idx, packB(), expPack(16, 16, nvB, mB, tB, actB));
      cntBusyA   += int'(busA.busy);
      cntIfmA    += int'(busA.ifm_rd);
      cntDoneA   += int'(busA.done);
      cntMacd3A  += int'(busA.mac_done[3]);
      cntEnoA    += int'(|busA.en_o);
      cntEnIanyA += int'(|busA.en_i);
      cntTripleA += int'(busA.clr_i[0] & busA.mac_done[0] & busA.ifm_rd);
      cntBusyB   += int'(busB.busy);
      cntOfmB    += int'(busB.ofm_vld);
      cntEnI15B  += int'(busB.en_i[15]);
      if (busA.ifm_rd && ifmN < 4) begin
        ifmAt[ifmN] = idx - jobMark;
        ifmN++;
      end
      if (busA.mac_done[3] && macd3N < 4) begin
        macd3At[macd3N] = idx - jobMark;
        macd3N++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sel, input bit st, input int nv, input int mc);
    if (sel == 1'b0) begin
      busA.start   = st;
      busA.num_vec = 6'(nv);
      busA.mac_cyc = 4'(mc);
    end else begin
      busB.start   = st;
      busB.num_vec = 16'(nv);
      busB.mac_cyc = 8'(mc);
    end
  endtask

  // Single-cycle start pulse followed by nSteps cycles of observation.
  task automatic runJob(input bit sel, input int nv, input int mc, input int nSteps);
    jobMark = cycIdx + 1;
    ifmN    = 0;
    macd3N  = 0;
    applyStimulus(sel, 1'b1, nv, mc);
    step();
    applyStimulus(sel, 1'b0, nv, mc);
    repeat (nSteps - 1) step();
  endtask

  int b0, b1, b2, b3, b4, b5;

  initial begin
    applyStimulus(1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0);

    // Reset with start requests asserted; they must be ignored.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 2, 3);
    applyStimulus(1'b1, 1'b1, 1, 1);
    step();
    checking = 1'b1;
    step();
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkOutput("reset_stateA", -1, packA(), 128'd0);
    checkOutput("reset_stateB", -1, packB(), 128'd0);
    b0 = cntBusyA;
    repeat (5) step();
    checkCount("start_during_reset_busy", cntBusyA - b0, 0);

    // Two vectors, three-cycle windows.
    b0 = cntBusyA; b1 = cntIfmA; b2 = cntDoneA; b3 = cntMacd3A;
    runJob(1'b0, 2, 3, 30);
    checkCount("job1_busy_cycles", cntBusyA - b0, 22);
    checkCount("job1_ifm_pulses", cntIfmA - b1, 2);
    checkCount("job1_done_pulses", cntDoneA - b2, 1);
    checkCount("job1_macdone3_pulses", cntMacd3A - b3, 2);
    checkCount("job1_ifm_first", ifmAt[0], 4);
    checkCount("job1_ifm_second", ifmAt[1], 7);
    checkCount("job1_macdone3_first", macd3At[0], 9);
    checkCount("job1_macdone3_second", macd3At[1], 12);

    // Single vector with mac_cyc 0: one compute cycle carrying everything.
    b0 = cntBusyA; b1 = cntTripleA;
    runJob(1'b0, 1, 0, 25);
    checkCount("job2_busy_cycles", cntBusyA - b0, 17);
    checkCount("job2_clr_macdone_ifm", cntTripleA - b1, 1);

    // Empty job: weights load, then straight to done.
    b0 = cntBusyA; b1 = cntEnIanyA; b2 = cntIfmA; b3 = cntEnoA; b4 = cntDoneA;
    runJob(1'b0, 0, 5, 12);
    checkCount("job3_busy_cycles", cntBusyA - b0, 5);
    checkCount("job3_en_i_cycles", cntEnIanyA - b1, 0);
    checkCount("job3_ifm_pulses", cntIfmA - b2, 0);
    checkCount("job3_en_o_cycles", cntEnoA - b3, 0);
    checkCount("job3_done_pulses", cntDoneA - b4, 1);

    // Reset in compute cycle 2, then a fresh job.
    applyStimulus(1'b0, 1'b1, 2, 3);
    step();
    applyStimulus(1'b0, 1'b0, 2, 3);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_outputs_zero", -1, packA(), 128'd0);
    b0 = cntEnIanyA; b1 = cntBusyA;
    repeat (20) step();
    checkCount("abort_no_late_en_i", cntEnIanyA - b0, 0);
    checkCount("abort_stays_idle", cntBusyA - b1, 0);
    b0 = cntBusyA;
    runJob(1'b0, 2, 3, 30);
    checkCount("after_abort_busy", cntBusyA - b0, 22);

    // start held high: one job, an idle cycle, then exactly one more.
    b0 = cntDoneA; b1 = cntBusyA;
    applyStimulus(1'b0, 1'b1, 2, 3);
    repeat (46) step();
    applyStimulus(1'b0, 1'b0, 2, 3);
    repeat (30) step();
    checkCount("held_start_done_pulses", cntDoneA - b0, 2);
    checkCount("held_start_busy_cycles", cntBusyA - b1, 44);

    // Counter limits on the narrow instance: 63 vectors of 15 cycles.
    b0 = cntBusyA; b1 = cntIfmA;
    runJob(1'b0, 63, 15, 970);
    checkCount("max_busy_cycles", cntBusyA - b0, 961);
    checkCount("max_ifm_pulses", cntIfmA - b1, 63);

    // Default geometry, 255-cycle windows.
    b0 = cntBusyB; b1 = cntOfmB; b2 = cntEnI15B; b5 = cntDoneA;
    runJob(1'b1, 3, 255, 840);
    checkCount("wide_busy_cycles", cntBusyB - b0, 829);
    checkCount("wide_out_cycles", cntOfmB - b1, 16);
    checkCount("wide_en_i15_cycles", cntEnI15B - b2, 765);
    checkCount("wide_other_dut_quiet", cntDoneA - b5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
